// File: rtl/fpunpk_norm.sv
// fpunpk_norm: expands a packed single (32), double (64) or extended (80)
// operand into sign, a 17-bit two's-complement exponent with bias 16383, a
// 64-bit significand with an explicit integer bit, and a one-hot class.
// Denormal inputs are normalized STEP bits per cycle in the NORM state.
// Build option FPUNPK_FAST_DENORM_EN replaces the iterative normalization with
// a full leading-zero count and barrel shift at decode. In that build every
// operand has 1-cycle latency and STEP is unused. Results are identical in
// both builds.
module fpunpk_norm #(
    parameter int STEP = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [79:0] in_data,
    input  logic        isDBL,
    input  logic        isEXT,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic [16:0] out_exp,
    output logic [63:0] out_mant,
    output logic [4:0]  out_cls
);

    localparam logic [4:0] CLS_SNAN = 5'b10000;
    localparam logic [4:0] CLS_QNAN = 5'b01000;
    localparam logic [4:0] CLS_INF  = 5'b00100;
    localparam logic [4:0] CLS_DEN  = 5'b00010;
    localparam logic [4:0] CLS_ZERO = 5'b00001;

`ifdef FPUNPK_FAST_DENORM_EN
    typedef enum logic [1:0] {IDLE, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
`endif

    state_t state;

    // Leading-zero count of a 64-bit word; 64 when the word is zero.
    function automatic logic [6:0] lzc64(input logic [63:0] v);
        logic [6:0] n;
        n = 7'd64;
        for (int i = 0; i < 64; i++) begin
            if (v[i]) n = 7'(63 - i);
        end
        return n;
    endfunction

    logic        dec_sign;
    logic [16:0] dec_exp;
    logic [63:0] dec_mant;
    logic [4:0]  dec_cls;
    logic        dec_norm;   // decoded significand still lacks its integer bit

    // Field extraction and classification of the operand on in_data.
    always_comb begin
        dec_sign = 1'b0;
        dec_exp  = '0;
        dec_mant = '0;
        dec_cls  = CLS_ZERO;
        dec_norm = 1'b0;
        if (isEXT) begin
            dec_sign = in_data[79];
            if (in_data[78:64] == 15'h0) begin
                if (in_data[63:0] != 64'h0) begin
                    dec_cls  = CLS_DEN;
                    dec_exp  = 17'd1;
                    dec_mant = in_data[63:0];
                    dec_norm = !in_data[63];
                end
            end else begin
                dec_exp  = {2'b00, in_data[78:64]};
                dec_mant = in_data[63:0];
                if (!in_data[63])
                    dec_cls = CLS_SNAN;             // unnormal or pseudo-NaN/inf
                else if (in_data[78:64] != 15'h7FFF)
                    dec_cls = 5'b00000;
                else if (in_data[62:0] == 63'h0)
                    dec_cls = CLS_INF;
                else
                    dec_cls = in_data[62] ? CLS_QNAN : CLS_SNAN;
            end
        end else if (isDBL) begin
            dec_sign = in_data[63];
            if (in_data[62:52] == 11'h0) begin
                if (in_data[51:0] != 52'h0) begin
                    dec_cls  = CLS_DEN;
                    dec_exp  = 17'd15361;
                    dec_mant = {1'b0, in_data[51:0], 11'b0};
                    dec_norm = 1'b1;
                end
            end else begin
                dec_mant = {1'b1, in_data[51:0], 11'b0};
                if (in_data[62:52] == 11'h7FF) begin
                    dec_exp = 17'h07FFF;
                    if (in_data[51:0] == 52'h0) dec_cls = CLS_INF;
                    else dec_cls = in_data[51] ? CLS_QNAN : CLS_SNAN;
                end else begin
                    dec_exp = {6'b0, in_data[62:52]} + 17'd15360;
                    dec_cls = 5'b00000;
                end
            end
        end else begin
            dec_sign = in_data[31];
            if (in_data[30:23] == 8'h0) begin
                if (in_data[22:0] != 23'h0) begin
                    dec_cls  = CLS_DEN;
                    dec_exp  = 17'd16257;
                    dec_mant = {1'b0, in_data[22:0], 40'b0};
                    dec_norm = 1'b1;
                end
            end else begin
                dec_mant = {1'b1, in_data[22:0], 40'b0};
                if (in_data[30:23] == 8'hFF) begin
                    dec_exp = 17'h07FFF;
                    if (in_data[22:0] == 23'h0) dec_cls = CLS_INF;
                    else dec_cls = in_data[22] ? CLS_QNAN : CLS_SNAN;
                end else begin
                    dec_exp = {9'b0, in_data[30:23]} + 17'd16256;
                    dec_cls = 5'b00000;
                end
            end
        end
    end

    logic [16:0] ld_exp;
    logic [63:0] ld_mant;
    state_t      ld_state;

`ifdef FPUNPK_FAST_DENORM_EN
    logic [6:0] dec_lz;

    // Full normalization at decode so every operand goes straight to DONE.
    always_comb begin
        dec_lz   = lzc64(dec_mant);
        ld_exp   = dec_norm ? dec_exp - 17'(dec_lz) : dec_exp;
        ld_mant  = dec_norm ? dec_mant << dec_lz : dec_mant;
        ld_state = DONE;
    end
`else
    logic [6:0]  norm_lz;
    logic [6:0]  norm_sh;
    logic [63:0] norm_mant;

    // Decoded values load as is; denormals continue in NORM.
    always_comb begin
        ld_exp   = dec_exp;
        ld_mant  = dec_mant;
        ld_state = dec_norm ? NORM : DONE;
    end

    // One normalization step: shift by the leading-zero count, capped at STEP.
    always_comb begin
        norm_lz   = lzc64(out_mant);
        norm_sh   = (norm_lz > 7'(STEP)) ? 7'(STEP) : norm_lz;
        norm_mant = out_mant << norm_sh;
    end
`endif

    assign out_valid = (state == DONE);
    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);

    // Control FSM and result registers; rst outranks flush, flush outranks accept.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state    <= IDLE;
            out_sign <= 1'b0;
            out_exp  <= '0;
            out_mant <= '0;
            out_cls  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= ld_state;
                        out_sign <= dec_sign;
                        out_exp  <= ld_exp;
                        out_mant <= ld_mant;
                        out_cls  <= dec_cls;
                    end
                end
`ifndef FPUNPK_FAST_DENORM_EN
                NORM: begin
                    out_mant <= norm_mant;
                    out_exp  <= out_exp - 17'(norm_sh);
                    if (norm_mant[63]) state <= DONE;
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            state    <= ld_state;
                            out_sign <= dec_sign;
                            out_exp  <= ld_exp;
                            out_mant <= ld_mant;
                            out_cls  <= dec_cls;
                        end else begin
                            state    <= IDLE;
                            out_sign <= 1'b0;
                            out_exp  <= '0;
                            out_mant <= '0;
                            out_cls  <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpunpk_norm.sv
// Scoreboard bench for fpunpk_norm: the driver pushes the value-level expected
// result of each accepted operand; an independent monitor pops and compares
// whenever the unit presents a result, and also checks latency and holding.
module tb_fpunpk_norm;

    localparam int STEP = 8;

    localparam logic [4:0] C_SNAN = 5'b10000;
    localparam logic [4:0] C_QNAN = 5'b01000;
    localparam logic [4:0] C_INF  = 5'b00100;
    localparam logic [4:0] C_DEN  = 5'b00010;
    localparam logic [4:0] C_ZERO = 5'b00001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [79:0] in_data = '0;
    logic        isDBL = 1'b0;
    logic        isEXT = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sign;
    logic [16:0] out_exp;
    logic [63:0] out_mant;
    logic [4:0]  out_cls;

    fpunpk_norm #(.STEP(STEP)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .isDBL(isDBL), .isEXT(isEXT),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant), .out_cls(out_cls)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sign;
        logic [16:0] exp;
        logic [63:0] mant;
        logic [4:0]  cls;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int cycle = 0;
    bit rand_ready = 1'b0;

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    function automatic int top_bit(input logic [63:0] v);
        int p;
        p = -1;
        for (int i = 0; i < 64; i++) if (v[i]) p = i;
        return p;
    endfunction

    function automatic int lat_of(input int lz0);
`ifdef FPUNPK_FAST_DENORM_EN
        return 1;
`else
        return 1 + (lz0 + STEP - 1) / STEP;
`endif
    endfunction

    // Reference: interprets the operand as a value and re-expresses it with bias 16383.
    function automatic exp_t model(input logic [79:0] d, input logic dbl, input logic ext);
        exp_t r;
        int p;
        r.sign = 1'b0; r.exp = '0; r.mant = '0; r.cls = C_ZERO; r.lat = 1; r.acc = 0;
        if (ext) begin
            logic [14:0] e;
            logic [63:0] m;
            e = d[78:64];
            m = d[63:0];
            r.sign = d[79];
            if (e == 0) begin
                if (m != 0) begin
                    // value = m * 2^(1-16383-63)
                    p = top_bit(m);
                    r.mant = m << (63 - p);
                    r.exp  = 17'(p - 62);
                    r.cls  = C_DEN;
                    r.lat  = lat_of(63 - p);
                end
            end else begin
                r.exp  = {2'b00, e};
                r.mant = m;
                if (!m[63]) r.cls = C_SNAN;
                else if (e != 15'h7FFF) r.cls = 5'b0;
                else if (m[62:0] == 0) r.cls = C_INF;
                else r.cls = m[62] ? C_QNAN : C_SNAN;
            end
        end else begin
            longint unsigned bits, f, e, emax;
            int fw, ew, bias;
            fw   = dbl ? 52 : 23;
            ew   = dbl ? 11 : 8;
            bias = dbl ? 1023 : 127;
            bits = dbl ? d[63:0] : {32'b0, d[31:0]};
            f    = bits & ((64'd1 << fw) - 1);
            e    = (bits >> fw) & ((64'd1 << ew) - 1);
            emax = (64'd1 << ew) - 1;
            r.sign = bits[fw + ew];
            if (e == 0) begin
                if (f != 0) begin
                    // value = f * 2^(1-bias-fw)
                    p = top_bit(f);
                    r.mant = f << (63 - p);
                    r.exp  = 17'(16383 + p - (bias - 1 + fw));
                    r.cls  = C_DEN;
                    r.lat  = lat_of(fw - p);
                end
            end else begin
                r.mant = (64'd1 << 63) | (f << (63 - fw));
                if (e == emax) begin
                    r.exp = 17'h07FFF;
                    if (f == 0) r.cls = C_INF;
                    else r.cls = ((f >> (fw - 1)) & 1) != 0 ? C_QNAN : C_SNAN;
                end else begin
                    r.exp = 17'(int'(e) - bias + 16383);
                    r.cls = 5'b0;
                end
            end
        end
        return r;
    endfunction

    // Present one operand; call #1 after a rising edge, returns #1 after the accept edge.
    task automatic send(input logic [79:0] d, input logic dbl, input logic ext);
        bit ok;
        exp_t r;
        in_data = d; isDBL = dbl; isEXT = ext; in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (ok) begin
            r = model(d, dbl, ext);
            r.acc = cycle;
            q.push_back(r);
            @(posedge clk); #1;
        end else begin
            total++; bad++;
            $display("FAIL accept_timeout: in_ready=%0b required=1", in_ready);
        end
        in_valid = 1'b0;
        in_data = {$urandom, $urandom, $urandom};
    endtask

    task automatic drain();
        for (int t = 0; t < 2000 && q.size() != 0; t++) @(posedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d required=0", q.size());
        end
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            {out_sign, out_exp, out_mant, out_cls} !== '0) begin
            bad++;
            $display("FAIL %s: out_valid=%0b in_ready=%0b exp=%h mant=%h cls=%b required 0/1/zeros",
                     name, out_valid, in_ready, out_exp, out_mant, out_cls);
        end
    endtask

    // Monitor: compares presented results against the scoreboard head.
    initial begin
        bit held;
        logic [87:0] prev;
        exp_t e;
        held = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_result: exp=%h mant=%h cls=%b required no output",
                             out_exp, out_mant, out_cls);
                end else begin
                    e = q[0];
                    if (!held) begin
                        total++;
                        if (cycle - e.acc != e.lat) begin
                            bad++;
                            $display("FAIL latency: got=%0d required=%0d", cycle - e.acc, e.lat);
                        end
                    end else begin
                        total++;
                        if ({out_sign, out_exp, out_mant, out_cls} !== prev[87:0]) begin
                            bad++;
                            $display("FAIL hold_stable: now=%h before=%h",
                                     {out_sign, out_exp, out_mant, out_cls}, prev);
                        end
                    end
                    if (!out_ready) begin
                        total++;
                        if (in_ready !== 1'b0) begin
                            bad++;
                            $display("FAIL in_ready_stall: got=%0b required=0", in_ready);
                        end
                    end
                    total++;
                    if (out_sign !== e.sign || out_exp !== e.exp || out_mant !== e.mant || out_cls !== e.cls) begin
                        bad++;
                        $display("FAIL result: got s=%0b e=%h m=%h c=%b required s=%0b e=%h m=%h c=%b",
                                 out_sign, out_exp, out_mant, out_cls, e.sign, e.exp, e.mant, e.cls);
                    end
                    if (out_ready) begin
                        void'(q.pop_front());
                        held = 1'b0;
                    end else begin
                        held = 1'b1;
                        prev = {out_sign, out_exp, out_mant, out_cls};
                    end
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    // Random consumer back-pressure during the random phase.
    initial forever begin
        @(posedge clk); #1;
        if (rand_ready) out_ready = ($urandom % 4) != 0;
    end

    initial begin
        logic [95:0] rr;
        logic [79:0] d;
        int fmt, k, sh;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_idle("reset_state");
        @(posedge clk); #1;

        // Basic values from each format, including the slow denormals.
        send(80'h3F800000, 1'b0, 1'b0);
        send(80'h00000001, 1'b0, 1'b0);
        send(80'h7FF0000000000000, 1'b1, 1'b0);
        send(80'h7F800001, 1'b0, 1'b0);
        send(80'h7FC00000, 1'b0, 1'b0);
        send(80'h0000_0000000000000001, 1'b0, 1'b1);
        send(80'h8000_0000000000000000, 1'b1, 1'b0);
        send(80'h0000_000FFFFFFFFFFFFF, 1'b1, 1'b0);
        send(80'h3FFF_8000000000000000, 1'b0, 1'b1);
        drain();

        // Consumer stall, then release together with the next operand.
        out_ready = 1'b0;
        send(80'h3F800000, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
        send(80'h40000000, 1'b0, 1'b0);
        drain();

        // Flush in the middle of a long normalization.
        send(80'h0000_0000000000000001, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        q.delete();
        check_idle("flush_in_norm");
        @(posedge clk); #1;
        send(80'h40000000, 1'b0, 1'b0);
        drain();

        // Reset in the middle of a long normalization.
        send(80'h0000_0000000000000001, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        q.delete();
        check_idle("rst_in_norm");
        @(posedge clk); #1;
        send(80'h40000000, 1'b0, 1'b0);
        drain();

        // Flush wins over an accept in the same cycle.
        in_data = 80'h3F800000; isDBL = 1'b0; isEXT = 1'b0;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        check_idle("flush_beats_accept");
        @(posedge clk); #1;

        // Random operands with random back-pressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 400; n++) begin
            rr  = {$urandom, $urandom, $urandom};
            d   = rr[79:0];
            fmt = $urandom % 3;
            k   = $urandom % 6;
            sh  = $urandom % 64;
            case (fmt)
                0: case (k)
                    0: d[30:0] = '0;
                    1: begin
                        d[30:23] = '0;
                        d[22:0] = d[22:0] >> (sh % 23);
                        if (d[22:0] == 0) d[0] = 1'b1;
                    end
                    2: begin
                        d[30:23] = 8'hFF;
                        if (sh < 20) d[22:0] = '0;
                    end
                    default: ;
                endcase
                1: case (k)
                    0: d[62:0] = '0;
                    1: begin
                        d[62:52] = '0;
                        d[51:0] = d[51:0] >> (sh % 52);
                        if (d[51:0] == 0) d[0] = 1'b1;
                    end
                    2: begin
                        d[62:52] = 11'h7FF;
                        if (sh < 20) d[51:0] = '0;
                    end
                    default: ;
                endcase
                default: case (k)
                    0: d[78:0] = '0;
                    1: begin
                        d[78:64] = '0;
                        d[63:0] = d[63:0] >> sh;
                        if (d[63:0] == 0) d[0] = 1'b1;
                    end
                    2: begin
                        d[78:64] = 15'h7FFF;
                        if (sh < 20) d[63:0] = 64'h8000000000000000;
                        else if (sh < 50) d[63] = 1'b1;
                    end
                    default: if (sh < 48) d[63] = 1'b1;
                endcase
            endcase
            send(d, fmt == 1, fmt == 2);
        end
        rand_ready = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
